button_debounce: RTL and testbench
==================================

# button_debounce

Input-side counterpart to the LED divider: reads a bouncing mechanical pushbutton pin and turns it into a clean level plus single-cycle events. The pin is synchronised into the 10 kHz SB_LFOSC domain, qualified by a debounce counter, and then classified as press, release or long-press. It sits between a top-level button pin and any control logic that needs clean events, for example mode stepping of LED patterns.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser flops, ≥2.
- `DEBOUNCE_CYCLES`, 200: consecutive agreeing samples needed to accept a change (20 ms at 10 kHz), ≥1.
- `HOLD_CYCLES`, 10000: cycles a qualified press lasts before `long_press` fires (1 s), greater than `DEBOUNCE_CYCLES`.
- `BTN_ACTIVE_LOW`, 1: 1 means the pin reads 0 when pressed (pull-up).

Ports:
- `clk`  in  1: single clock, 10 kHz LFOSC.
- `rst`  in  1: asynchronous, active-low reset.
- `btn`  in  1: raw pin, asynchronous, bouncing.
- `pressed`  out  1: debounced level, 1 = pressed.
- `press_pulse`  out  1: one-cycle pulse when a press is accepted.
- `release_pulse`  out  1: one-cycle pulse when a release is accepted.
- `long_press`  out  1: one-cycle pulse when a press has been held for `HOLD_CYCLES`.
- `press_count`  out  8: accepted presses, wraps 255→0.

## Operation
- The raw pin is normalised to active-high (`raw = btn ^ BTN_ACTIVE_LOW`), then passed through `SYNC_STAGES` flops. The last stage is `s`.
- State machine states:
  - IDLE: while `s=1`, go to PRESS_QUAL and set `dcnt=1`.
  - PRESS_QUAL: if `s=0`, return to IDLE with `dcnt=0`. Otherwise increment `dcnt`. At `dcnt==DEBOUNCE_CYCLES`, go to PRESSED, pulse `press_pulse`, increment `press_count`, and clear `hcnt`.
  - PRESSED: `hcnt` increments each cycle. At `hcnt==HOLD_CYCLES`, pulse `long_press` and go to HELD. If `s=0`, go to RELEASE_QUAL with `dcnt=1`.
  - HELD: if `s=0`, go to RELEASE_QUAL with `dcnt=1`. No further `long_press` pulses.
  - RELEASE_QUAL: `hcnt` is frozen. If `s=1`, return to HELD if the `long_fired` flag is set, else to PRESSED with `hcnt` resumed. Otherwise increment `dcnt`. At `dcnt==DEBOUNCE_CYCLES`, go to IDLE, pulse `release_pulse`, and clear `long_fired`.
- `pressed` = 1 in PRESSED, HELD and RELEASE_QUAL.
- Counter width is `$clog2(HOLD_CYCLES+1)` for both `dcnt` and `hcnt`. `hcnt` saturates at `HOLD_CYCLES`.
- Simultaneous events:
  - If `hcnt` reaches `HOLD_CYCLES` in the same cycle that `s` falls in PRESSED, `long_press` still fires, `long_fired` is set, and the next state is RELEASE_QUAL.
  - At most one pulse output is high in any cycle, except for that `long_press` case.

## Timing
- Reset values:
  - State is IDLE; `dcnt`, `hcnt` and `long_fired` are 0.
  - The synchroniser flops reset to the inactive level, so `s=0`.
  - All outputs are 0.
- Reset mid-press: all state is cleared immediately and no pulses are emitted. If the button is still held after reset, it requalifies as a fresh press.
- Press latency: from a clean, stable edge on `btn`, `press_pulse` is high exactly `SYNC_STAGES + DEBOUNCE_CYCLES` cycles later, and `pressed` rises in the same cycle.
- Release latency is the same as press latency.
- `long_press` fires `HOLD_CYCLES` cycles after `press_pulse`, excluding cycles spent in RELEASE_QUAL.
- A glitch shorter than `DEBOUNCE_CYCLES` produces no output change.
- All outputs are registered.

## Structure
- A shared header `button_defs.vh` holds the state encodings (IDLE=0, PRESS_QUAL=1, PRESSED=2, HELD=3, RELEASE_QUAL=4; 3 bits) and the default 10 kHz timing constants.
- Sub-module `sync_ff`: a parameterised `SYNC_STAGES` flop chain with async active-low reset and a reset value parameter. It is reused for other pin inputs.

## Test plan
Sim parameters: `DEBOUNCE_CYCLES=4`, `HOLD_CYCLES=20`, `SYNC_STAGES=2`, `BTN_ACTIVE_LOW=1`.
1. Clean press: `btn` 1→0 held → `press_pulse` exactly 6 cycles after the edge, `pressed=1`, `press_count=1`. Then `btn` 0→1 → `release_pulse` 6 cycles later, `pressed=0`.
2. Bounce: `btn` low for 3 cycles, high for 1, low for 3, then high → no pulses, `pressed` stays 0, `press_count=0`.
3. Long press: hold low for 40 cycles → `long_press` 20 cycles after `press_pulse`, exactly once. Release → single `release_pulse`.
4. Release bounce: in PRESSED with `hcnt=10`, `btn` high for 2 cycles then low → no `release_pulse`, `pressed` stays 1, `long_press` at `hcnt=20`. Verify the 2 RELEASE_QUAL cycles are excluded from the count.
5. Wrap and reset: 256 clean presses → `press_count=0`. Assert `rst=0` mid-PRESS_QUAL and mid-HELD → outputs go 0 asynchronously. Release `rst` with `btn` held → a fresh `press_pulse` after 6 cycles.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// Shared state encodings, default 10 kHz timing constants and pulse payload for the pushbutton debouncer.
package button_debounce_pkg;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 200;    // 20 ms at 10 kHz
    localparam int unsigned DEF_HOLD_CYCLES     = 10000;  // 1 s at 10 kHz
    localparam int unsigned PRESS_COUNT_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_PRESS_QUAL   = 3'd1,
        ST_PRESSED      = 3'd2,
        ST_HELD         = 3'd3,
        ST_RELEASE_QUAL = 3'd4
    } state_t;

    typedef struct packed {
        logic press;
        logic rel;
        logic long_hold;
    } pulse_t;

    // Debounced level is high whenever a press has been accepted and not yet released.
    function automatic logic is_pressed_state(input state_t st);
        return (st == ST_PRESSED) || (st == ST_HELD) || (st == ST_RELEASE_QUAL);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchroniser for asynchronous pin inputs, reusable for any pin width.
module sync_ff #(
    parameter int unsigned           STAGES  = 2,
    parameter int unsigned           WIDTH   = 1,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES*WIDTH-1:0] chain;

    // Shift the pin through the flop chain; oldest sample sits in the top slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[(STAGES-1)*WIDTH-1:0], d};
        end
    end

    assign q = chain[STAGES*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/button_debounce.sv
// Pushbutton debouncer: synchronises the pin, qualifies level changes and emits press/release/long-press events.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     btn,
    output logic                     pressed,
    output logic                     press_pulse,
    output logic                     release_pulse,
    output logic                     long_press,
    output logic [PRESS_COUNT_W-1:0] press_count
);

    localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

    logic                     raw;
    logic                     s;

    state_t                   state_q, state_d;
    logic [CW-1:0]            dcnt_q, dcnt_d;
    logic [CW-1:0]            hcnt_q, hcnt_d;
    logic                     long_fired_q, long_fired_d;
    pulse_t                   pulse_q, pulse_d;
    logic                     pressed_q, pressed_d;
    logic [PRESS_COUNT_W-1:0] count_q, count_d;

    logic [CW-1:0]            dstep;
    logic                     dhit;
    logic [CW-1:0]            hstep;
    logic                     hhit;

    // Normalise to active-high before synchronising so the reset value is always the released level.
    assign raw = btn ^ BTN_ACTIVE_LOW;

    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (raw),
        .q     (s)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            dcnt_q       <= '0;
            hcnt_q       <= '0;
            long_fired_q <= 1'b0;
            pulse_q      <= '0;
            pressed_q    <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            dcnt_q       <= dcnt_d;
            hcnt_q       <= hcnt_d;
            long_fired_q <= long_fired_d;
            pulse_q      <= pulse_d;
            pressed_q    <= pressed_d;
            count_q      <= count_d;
        end
    end

    // Next-state, counter and pulse decode; a qualifying window starts at 1 and accepts when it reaches DEBOUNCE_CYCLES.
    always_comb begin
        state_d      = state_q;
        dcnt_d       = dcnt_q;
        hcnt_d       = hcnt_q;
        long_fired_d = long_fired_q;
        pulse_d      = '0;
        count_d      = count_q;

        dstep = ((state_q == ST_PRESS_QUAL) || (state_q == ST_RELEASE_QUAL))
                ? dcnt_q + CW'(1) : CW'(1);
        dhit  = (dstep == CW'(DEBOUNCE_CYCLES));
        hstep = (hcnt_q == CW'(HOLD_CYCLES)) ? hcnt_q : hcnt_q + CW'(1);
        hhit  = (hstep == CW'(HOLD_CYCLES));

        case (state_q)
            ST_IDLE, ST_PRESS_QUAL: begin
                if (!s) begin
                    state_d = ST_IDLE;
                    dcnt_d  = '0;
                end else if (dhit) begin
                    state_d       = ST_PRESSED;
                    dcnt_d        = '0;
                    hcnt_d        = '0;
                    pulse_d.press = 1'b1;
                    count_d       = count_q + PRESS_COUNT_W'(1);
                end else begin
                    state_d = ST_PRESS_QUAL;
                    dcnt_d  = dstep;
                end
            end

            ST_PRESSED, ST_HELD: begin
                if (state_q == ST_PRESSED) begin
                    hcnt_d = hstep;
                    if (hhit) begin
                        state_d           = ST_HELD;
                        long_fired_d      = 1'b1;
                        pulse_d.long_hold = 1'b1;
                    end
                end
                if (!s) begin
                    if (dhit) begin
                        state_d      = ST_IDLE;
                        dcnt_d       = '0;
                        hcnt_d       = '0;
                        long_fired_d = 1'b0;
                        pulse_d.rel  = 1'b1;
                    end else begin
                        state_d = ST_RELEASE_QUAL;
                        dcnt_d  = dstep;
                    end
                end
            end

            ST_RELEASE_QUAL: begin
                // Hold counter stays frozen here so bounce time does not count towards a long press.
                if (s) begin
                    state_d = long_fired_q ? ST_HELD : ST_PRESSED;
                    dcnt_d  = '0;
                end else if (dhit) begin
                    state_d      = ST_IDLE;
                    dcnt_d       = '0;
                    hcnt_d       = '0;
                    long_fired_d = 1'b0;
                    pulse_d.rel  = 1'b1;
                end else begin
                    dcnt_d = dstep;
                end
            end

            default: begin
                state_d = ST_IDLE;
                dcnt_d  = '0;
                hcnt_d  = '0;
            end
        endcase

        pressed_d = is_pressed_state(state_d);
    end

    assign pressed       = pressed_q;
    assign press_pulse   = pulse_q.press;
    assign release_pulse = pulse_q.rel;
    assign long_press    = pulse_q.long_hold;
    assign press_count   = count_q;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce with short simulation timing constants.
module tb_button_debounce;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 4;
    localparam int unsigned HOLD = 20;
    localparam int          LAT  = SYNC + DEB;

    localparam int EV_PRESS = 1;
    localparam int EV_LONG  = 2;
    localparam int EV_REL   = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic       pressed;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_press;
    logic [7:0] press_count;

    button_debounce #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn           (btn),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int cyc;
        int cnt;
        int prs;
    } evt_t;

    evt_t sb[$];
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   exp_cnt = 0;
    int   t0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int at, input int prs);
        evt_t e;
        if (kind == EV_PRESS) exp_cnt = (exp_cnt + 1) % 256;
        e.kind = kind;
        e.cyc  = at;
        e.cnt  = exp_cnt;
        e.prs  = prs;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int b;
        b = budget;
        while (sb.size() != 0 && b > 0) begin
            tick(1);
            b--;
        end
        check_eq("drain", sb.size(), 0);
    endtask

    task automatic expect_evt(input int kind);
        evt_t e;
        if (sb.size() == 0) begin
            check_eq("spurious_pulse", kind, 0);
        end else begin
            e = sb.pop_front();
            check_eq("evt_kind", kind, e.kind);
            check_eq("evt_cycle", cyc, e.cyc);
            check_eq("evt_count", int'(press_count), e.cnt);
            check_eq("evt_pressed", int'(pressed), e.prs);
        end
    endtask

    // Pop and compare one expected event per observed pulse.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (press_pulse)   expect_evt(EV_PRESS);
            if (long_press)    expect_evt(EV_LONG);
            if (release_pulse) expect_evt(EV_REL);
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_pressed"}, int'(pressed), 0);
        check_eq({tag, "_press_pulse"}, int'(press_pulse), 0);
        check_eq({tag, "_release_pulse"}, int'(release_pulse), 0);
        check_eq({tag, "_long_press"}, int'(long_press), 0);
        check_eq({tag, "_count"}, int'(press_count), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        btn = 1'b1;
        tick(3);
        check_all_zero("reset");
        #2 rst = 1'b1;
        tick(5);

        // Bounce shorter than the debounce window.
        btn = 1'b0; tick(3);
        btn = 1'b1; tick(1);
        btn = 1'b0; tick(3);
        btn = 1'b1; tick(10);
        check_eq("bounce_pressed", int'(pressed), 0);
        check_eq("bounce_count", int'(press_count), 0);
        drain(5);

        // Clean press and release.
        btn = 1'b0;
        push(EV_PRESS, cyc + LAT, 1);
        tick(LAT + 6);
        check_eq("t1_pressed", int'(pressed), 1);
        check_eq("t1_count", int'(press_count), 1);
        btn = 1'b1;
        push(EV_REL, cyc + LAT, 0);
        tick(LAT + 4);
        check_eq("t1_released", int'(pressed), 0);
        drain(20);
        tick(5);

        // Long press held for 40 cycles.
        btn = 1'b0;
        push(EV_PRESS, cyc + LAT, 1);
        push(EV_LONG, cyc + LAT + HOLD, 1);
        tick(40);
        btn = 1'b1;
        push(EV_REL, cyc + LAT, 0);
        drain(30);
        tick(5);

        // Release bounce at hcnt=10 delays long_press by the two frozen cycles.
        btn = 1'b0;
        t0 = cyc;
        push(EV_PRESS, t0 + LAT, 1);
        tick(16);
        btn = 1'b1;
        tick(2);
        btn = 1'b0;
        push(EV_LONG, t0 + LAT + HOLD + 2, 1);
        tick(2);
        check_eq("t4_pressed_rq", int'(pressed), 1);
        tick(1);
        check_eq("t4_pressed_back", int'(pressed), 1);
        tick(19);
        btn = 1'b1;
        push(EV_REL, cyc + LAT, 0);
        drain(30);
        tick(5);

        // 256 presses wrap the counter back to its starting value.
        for (int i = 0; i < 256; i++) begin
            btn = 1'b0;
            push(EV_PRESS, cyc + LAT, 1);
            tick(8);
            btn = 1'b1;
            push(EV_REL, cyc + LAT, 0);
            tick(8);
        end
        drain(30);
        check_eq("wrap_count", int'(press_count), exp_cnt);

        // Reset asserted mid press qualification.
        btn = 1'b0;
        tick(4);
        rst = 1'b0;
        #1;
        check_all_zero("rst_pq");
        exp_cnt = 0;
        tick(3);
        rst = 1'b1;
        push(EV_PRESS, cyc + LAT, 1);
        push(EV_LONG, cyc + LAT + HOLD, 1);
        tick(30);
        check_eq("held_pressed", int'(pressed), 1);
        drain(5);

        // Reset asserted while held, button still down afterwards.
        rst = 1'b0;
        #1;
        check_all_zero("rst_held");
        exp_cnt = 0;
        tick(3);
        rst = 1'b1;
        push(EV_PRESS, cyc + LAT, 1);
        tick(10);
        btn = 1'b1;
        push(EV_REL, cyc + LAT, 0);
        drain(30);
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
